// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with byte enables, RISC-V load/store sizing,
// and a small FSM that splits word-straddling accesses into two RAM operations.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr_out,
  input  logic        MemRW,
  input  logic [2:0]  RWType,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  output logic        mem_stall
);

  typedef enum logic [2:0] {StIdle, StRdLo, StRdHi, StResp, StWrHi} state_e;

  state_e        state_q;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   rd_data_q;
  logic [31:0]   lo_q;
  logic [31:0]   data_q;
  logic [2:0]    type_q;
  logic [1:0]    off_q;
  logic [AW-1:0] idx_q;
  logic          split_q;
  logic [3:0]    be_hi_q;
  logic [31:0]   wd_hi_q;

  // Request decode
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          legal;
  logic [2:0]    sz;
  logic          split;
  logic [3:0]    base_mask;
  logic [7:0]    mask8;
  logic [63:0]   wide_wdata;
  logic          unused_addr;

  assign idx         = addr_out[AW+1:2];
  assign off         = addr_out[1:0];
  assign unused_addr = ^addr_out[31:AW+2];

  always_comb begin
    legal     = 1'b0;
    sz        = 3'd4;
    base_mask = 4'b1111;
    case (RWType)
      3'b000, 3'b100: begin legal = 1'b1; sz = 3'd1; base_mask = 4'b0001; end
      3'b001, 3'b101: begin legal = 1'b1; sz = 3'd2; base_mask = 4'b0011; end
      3'b010:         begin legal = 1'b1; sz = 3'd4; base_mask = 4'b1111; end
      default:        begin legal = 1'b0; sz = 3'd4; base_mask = 4'b1111; end
    endcase
    split      = legal && (({2'b00, off} + {1'b0, sz}) > 4'd4);
    mask8      = {4'b0000, base_mask} << off;
    wide_wdata = {32'h0, data_out} << {off, 3'b000};
  end

  // RAM port control
  logic          we;
  logic [AW-1:0] waddr;
  logic [3:0]    wbe;
  logic [31:0]   wdata;
  logic          re;
  logic [AW-1:0] raddr;

  always_comb begin
    we    = 1'b0;
    waddr = idx;
    wbe   = mask8[3:0];
    wdata = wide_wdata[31:0];
    re    = 1'b0;
    raddr = idx;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          we = req && MemRW && legal;
          re = req && !MemRW;
        end
        StRdLo: begin
          re    = 1'b1;
          raddr = idx_q + AW'(1);
        end
        StWrHi: begin
          we    = 1'b1;
          waddr = idx_q + AW'(1);
          wbe   = be_hi_q;
          wdata = wd_hi_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rd_data_q <= mem[raddr];
  end

  // Load formatting: gather one or two words, right-justify, then extend.
  logic [63:0] pair;
  logic [31:0] gathered;
  logic [31:0] load_fmt;

  always_comb begin
    pair     = split_q ? {rd_data_q, lo_q} : {32'h0, rd_data_q};
    gathered = 32'(pair >> {off_q, 3'b000});
    case (type_q)
      3'b000:  load_fmt = {{24{gathered[7]}}, gathered[7:0]};
      3'b001:  load_fmt = {{16{gathered[15]}}, gathered[15:0]};
      3'b010:  load_fmt = gathered;
      3'b100:  load_fmt = {24'h0, gathered[7:0]};
      3'b101:  load_fmt = {16'h0, gathered[15:0]};
      default: load_fmt = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            type_q  <= RWType;
            off_q   <= off;
            idx_q   <= idx;
            split_q <= split;
            be_hi_q <= mask8[7:4];
            wd_hi_q <= wide_wdata[63:32];
            if (MemRW) begin
              if (split) state_q <= StWrHi;
            end else begin
              state_q <= split ? StRdLo : StResp;
            end
          end
        end
        StRdLo: begin
          lo_q    <= rd_data_q;
          state_q <= StRdHi;
        end
        StRdHi: state_q <= StResp;
        StResp: begin
          data_q  <= load_fmt;
          state_q <= StIdle;
        end
        StWrHi:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Result is presented combinationally in RESP and held afterwards.
  always_comb begin
    data_in = data_q;
    if (rst) data_in = 32'h0;
    else if (state_q == StResp) data_in = load_fmt;
  end

  always_comb begin
    mem_stall = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle:         mem_stall = req && (!MemRW || split);
        StRdLo, StRdHi: mem_stall = 1'b1;
        default:        mem_stall = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (16-word RAM).
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr_out;
  logic        MemRW;
  logic [2:0]  RWType;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        mem_stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .addr_out (addr_out),
    .MemRW    (MemRW),
    .RWType   (RWType),
    .data_out (data_out),
    .data_in  (data_in),
    .mem_stall(mem_stall)
  );

  // Drives one request, counts stall cycles (bounded) and returns data seen when stall drops.
  task automatic run_access(input logic wr, input logic [31:0] a, input logic [2:0] t,
                            input logic [31:0] d, output logic [31:0] rdata, output int stalls);
    @(negedge clk);
    req = 1'b1; MemRW = wr; addr_out = a; RWType = t; data_out = d;
    stalls = 0;
    #1;
    while (mem_stall && stalls < 8) begin
      @(posedge clk); #1;
      stalls++;
    end
    rdata = data_in;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b1; MemRW = 1'b0; RWType = 3'b010; addr_out = 32'h10; data_out = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", mem_stall); end
    n_checks++; if (data_in !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", data_in); end
    @(negedge clk); rst = 1'b0; req = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL idle_stall: got %b want 0", mem_stall); end
    n_checks++; if (data_in !== 32'h0) begin n_fail++; $display("FAIL idle_data: got %h want 0", data_in); end
  endtask

  task automatic test_word;
    logic [31:0] r; int s;
    run_access(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, r, s);
    n_checks++; if (s !== 0) begin n_fail++; $display("FAIL sw_stall: got %0d want 0", s); end
    run_access(1'b0, 32'h10, 3'b010, 32'h0, r, s);
    n_checks++; if (s !== 1) begin n_fail++; $display("FAIL lw_stall: got %0d want 1", s); end
    n_checks++; if (r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", r); end
  endtask

  task automatic test_byte_half;
    logic [31:0] r; int s;
    logic [31:0] addrs [5] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
    logic [2:0]  types [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] exps  [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD, 32'hFFFFFFEF};
    for (int i = 0; i < 5; i++) begin
      run_access(1'b0, addrs[i], types[i], 32'h0, r, s);
      n_checks++;
      if (r !== exps[i] || s !== 1) begin
        n_fail++; $display("FAIL subword_load%0d: got %h/%0d want %h/1", i, r, s, exps[i]);
      end
    end
  endtask

  task automatic test_sb;
    logic [31:0] r; int s;
    run_access(1'b1, 32'h11, 3'b000, 32'hAAAAAA55, r, s);
    n_checks++; if (s !== 0) begin n_fail++; $display("FAIL sb_stall: got %0d want 0", s); end
    run_access(1'b0, 32'h10, 3'b010, 32'h0, r, s);
    n_checks++; if (r !== 32'hDEAD55EF) begin n_fail++; $display("FAIL sb_word: got %h want dead55ef", r); end
  endtask

  task automatic test_split;
    logic [31:0] r; int s;
    run_access(1'b1, 32'h0C, 3'b010, 32'h0, r, s);
    run_access(1'b1, 32'h0E, 3'b010, 32'h11223344, r, s);
    n_checks++; if (s !== 1) begin n_fail++; $display("FAIL split_sw_stall: got %0d want 1", s); end
    run_access(1'b0, 32'h0C, 3'b010, 32'h0, r, s);
    n_checks++; if (r !== 32'h33440000) begin n_fail++; $display("FAIL split_lo_word: got %h want 33440000", r); end
    run_access(1'b0, 32'h10, 3'b010, 32'h0, r, s);
    n_checks++; if (r !== 32'hDEAD1122) begin n_fail++; $display("FAIL split_hi_word: got %h want dead1122", r); end
    run_access(1'b0, 32'h0F, 3'b001, 32'h0, r, s);
    n_checks++; if (r !== 32'h00002233 || s !== 3) begin n_fail++; $display("FAIL split_lh: got %h/%0d want 00002233/3", r, s); end
    run_access(1'b0, 32'h0E, 3'b010, 32'h0, r, s);
    n_checks++; if (s !== 3) begin n_fail++; $display("FAIL split_lw_stall: got %0d want 3", s); end
    n_checks++; if (r !== 32'h11223344) begin n_fail++; $display("FAIL split_lw_data: got %h want 11223344", r); end
  endtask

  task automatic test_reset_rdhi;
    logic [31:0] r; int s;
    @(negedge clk);
    req = 1'b1; MemRW = 1'b0; addr_out = 32'h0E; RWType = 3'b010;
    repeat (2) @(posedge clk);   // now in RD_HI
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (data_in !== 32'h0) begin n_fail++; $display("FAIL rdhi_rst_data: got %h want 0", data_in); end
    n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rdhi_rst_stall: got %b want 0", mem_stall); end
    @(negedge clk); rst = 1'b0; req = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (data_in !== 32'h0 || mem_stall !== 1'b0) begin
      n_fail++; $display("FAIL rdhi_after: got %h/%b want 0/0", data_in, mem_stall);
    end
    run_access(1'b0, 32'h10, 3'b010, 32'h0, r, s);
    n_checks++; if (r !== 32'hDEAD1122 || s !== 1) begin n_fail++; $display("FAIL rdhi_recover: got %h/%0d want dead1122/1", r, s); end
  endtask

  task automatic test_reset_wrhi;
    logic [31:0] r; int s;
    @(negedge clk);
    req = 1'b1; MemRW = 1'b1; addr_out = 32'h0E; RWType = 3'b010; data_out = 32'hAABBCCDD;
    @(posedge clk);              // low half written, now in WR_HI
    @(negedge clk); rst = 1'b1; req = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    run_access(1'b0, 32'h0C, 3'b010, 32'h0, r, s);
    n_checks++; if (r !== 32'hCCDD0000) begin n_fail++; $display("FAIL wrhi_lo: got %h want ccdd0000", r); end
    run_access(1'b0, 32'h10, 3'b010, 32'h0, r, s);
    n_checks++; if (r !== 32'hDEAD1122) begin n_fail++; $display("FAIL wrhi_hi: got %h want dead1122", r); end
  endtask

  task automatic test_illegal;
    logic [31:0] r; int s;
    run_access(1'b1, 32'h10, 3'b011, 32'hFFFFFFFF, r, s);
    n_checks++; if (s !== 0) begin n_fail++; $display("FAIL ill_st_stall: got %0d want 0", s); end
    run_access(1'b0, 32'h10, 3'b010, 32'h0, r, s);
    n_checks++; if (r !== 32'hDEAD1122) begin n_fail++; $display("FAIL ill_st_ram: got %h want dead1122", r); end
    run_access(1'b0, 32'h0E, 3'b011, 32'h0, r, s);
    n_checks++; if (r !== 32'h0 || s !== 1) begin n_fail++; $display("FAIL ill_ld: got %h/%0d want 0/1", r, s); end
  endtask

  task automatic test_wrap;
    logic [31:0] r; int s;
    run_access(1'b1, 4*DEPTH - 4, 3'b010, 32'hAB000000, r, s);
    run_access(1'b1, 32'h0, 3'b010, 32'h000000CD, r, s);
    run_access(1'b0, 4*DEPTH - 1, 3'b001, 32'h0, r, s);
    n_checks++; if (r !== 32'hFFFFCDAB || s !== 3) begin n_fail++; $display("FAIL wrap_lh: got %h/%0d want ffffcdab/3", r, s); end
    run_access(1'b0, 4*DEPTH, 3'b010, 32'h0, r, s);
    n_checks++; if (r !== 32'h000000CD) begin n_fail++; $display("FAIL alias_lw: got %h want 000000cd", r); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    req = 1'b1; MemRW = 1'b0; addr_out = 32'h10; RWType = 3'b010;
    @(posedge clk); #1;
    n_checks++; if (data_in !== 32'hDEAD1122 || mem_stall !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first: got %h/%b want dead1122/0", data_in, mem_stall);
    end
    @(negedge clk); addr_out = 32'h00;   // next request follows RESP directly
    @(posedge clk); #1;
    n_checks++; if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall: got %b want 1", mem_stall); end
    @(posedge clk); #1;
    n_checks++; if (data_in !== 32'h000000CD || mem_stall !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second: got %h/%b want 000000cd/0", data_in, mem_stall);
    end
    @(negedge clk); req = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (data_in !== 32'h000000CD) begin n_fail++; $display("FAIL hold_data: got %h want 000000cd", data_in); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_sb();
    test_split();
    test_reset_rdhi();
    test_reset_wrhi();
    test_illegal();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the inner memory interface: serves the load/store requests the MEM stage drives (address, MemRW, RWType, store data) and returns load data on `data_in`. It holds a word-organised synchronous data RAM with byte enables. It performs RISC-V byte/half/word sizing with sign or zero extension. Accesses that straddle a word boundary are split into two RAM operations by a small FSM, and the pipeline is held with `mem_stall` until each access completes.

## Interface
- `DEPTH_WORDS`, default 1024: RAM depth in 32-bit words; must be a power of two.
- `AW`, default `$clog2(DEPTH_WORDS)`: word-index width.
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous active-high reset.
- `req`  in  1: access request from MEM; held stable by the pipeline while `mem_stall`=1.
- `addr_out`  in  32: byte address (ALU result).
- `MemRW`  in  1: 1 = store, 0 = load.
- `RWType`  in  3: funct3 encoding. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU. 011/110/111 are illegal.
- `data_out`  in  32: store data (rs2); the low bytes are used for B/H.
- `data_in`  out  32: load result, sized and extended.
- `mem_stall`  out  1: hold the pipeline; the request must stay unchanged.

## Operation
- Word index is `addr_out[AW+1:2]`; higher address bits are ignored, so addresses alias modulo the RAM size. Byte offset is `off = addr_out[1:0]`. Size `sz` is 1, 2 or 4 bytes.
- Bytes are little-endian: byte k of a word is bits `[8k+7:8k]`.
- An access is misaligned-split when `off + sz > 4`. The low part goes to word `idx`; the high part goes to word `(idx+1) mod DEPTH_WORDS`, which wraps to word 0 at the top.
- Store: only the addressed bytes are written, using byte enables from `off`/`sz`. Store data bytes are rotated into lane position.
- Load: bytes are gathered from one or two RAM words, right-justified, then extended.
  - B/H: sign-extended from bit 7 or bit 15.
  - BU/HU: zero-extended.
  - W: passed through unchanged.
- Illegal RWType:
  - Store: no RAM write.
  - Load: follows aligned-load timing and returns 0.
- FSM states: IDLE, RD_LO, RD_HI, RESP, WR_HI.
  - IDLE, `req`=0: nothing happens; `mem_stall`=0.
  - IDLE, aligned store: RAM write at the edge; `mem_stall`=0; stay in IDLE.
  - IDLE, split store: write the low part; `mem_stall`=1; go to WR_HI.
  - WR_HI: write the high part; `mem_stall`=0; go to IDLE.
  - IDLE, aligned or illegal load: issue RAM read; `mem_stall`=1; go to RESP.
  - IDLE, split load: issue read of the low word; `mem_stall`=1; go to RD_LO.
  - RD_LO: latch the low word; issue read of the high word; `mem_stall`=1; go to RD_HI.
  - RD_HI: `mem_stall`=1; go to RESP.
  - RESP: `data_in` is valid; `mem_stall`=0; go to IDLE unconditionally.
- The request still visible in RESP or WR_HI is the one just completed. It must not start a new access in that cycle.
- `data_in` holds its last value until the next RESP.

## Timing
- `mem_stall` is combinational from state and the request in IDLE, and registered-state driven elsewhere.
- RAM is synchronous: read data appears the cycle after the address is issued.
- Aligned store: 1 cycle, 0 stall cycles.
- Split store: 2 cycles, 1 stall cycle.
- Aligned load: 2 cycles; 1 stall cycle; data valid in cycle N+1, where N is the request cycle.
- Split load: 4 cycles; 3 stall cycles; data valid in cycle N+3.
- Reset values:
  - state = IDLE
  - `data_in` = 0
  - `mem_stall` = 0 while `rst`=1
  - RAM contents are not reset.
- Reset during RD_LO, RD_HI or RESP: the access is abandoned; state returns to IDLE; `data_in` = 0.
- Reset asserted in WR_HI: the high part is not written; the low part, already written, remains.
- Back-to-back requests: a new access can start in the cycle after RESP or WR_HI. The minimum gap between loads is 0 idle cycles beyond the required 2.

## Test plan
- SW of 0xDEADBEEF at 0x10 with no stall, then LW at 0x10:
  - `mem_stall` high exactly 1 cycle;
  - `data_in` = 0xDEADBEEF in the RESP cycle.
- LB/LBU at 0x13 after that word:
  - LB returns 0xFFFFFFDE;
  - LBU returns 0x000000DE.
- LH and LHU at 0x12:
  - LH returns 0xFFFFDEAD;
  - LHU returns 0x0000DEAD.
- SB of 0x55 at 0x11 → word 0x10 reads 0xDEAD55EF; neighbouring bytes unchanged.
- Split SW of 0x11223344 at 0x0E:
  - 1 stall cycle;
  - word 0x0C bytes[3:2] = 0x44,0x33;
  - word 0x10 bytes[1:0] = 0x22,0x11.
- Split LW at 0x0E then returns 0x11223344 after 3 stall cycles.
- Split LH at byte `4*DEPTH_WORDS-1` wraps to word 0. Separately, assert `rst` in RD_HI: state returns to IDLE, `data_in` = 0, `mem_stall` = 0.
- Illegal RWType 011 store leaves the RAM unchanged; 011 load returns 0 after 1 stall cycle.
